mips_step_ctrl: RTL and testbench

//  Execution controller for the MIPS core on the FPGA board. It replaces the raw push-button

---
 rtl/mips_dbg_pkg.sv | 14 +
 rtl/btn_debounce.sv | 43 ++++
 rtl/mips_step_ctrl.sv | 128 ++++++++++++
 tb/tb_mips_step_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared types and default timing for the MIPS execution controller
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BREAK = 2'd2
  } run_state_t;

  // 10 ms debounce and 2 Hz free-run at 50 MHz
  localparam int DB_CYCLES_DEFAULT = 500_000;
  localparam int RUN_DIV_DEFAULT   = 25_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, debounce filter and one-cycle press pulse
module btn_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // cnt tracks how long the synced input has disagreed with the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        press <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_step_ctrl.sv
// rtl/mips_step_ctrl.sv - step/run/breakpoint clock-enable controller with instruction counter
module mips_step_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int RUN_DIV   = RUN_DIV_DEFAULT,
  parameter int PC_W      = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_btn,
  input  logic             run_btn,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_en,
  output run_state_t       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic             step_level;
  logic             step_press;
  logic             run_level;
  logic             run_press;
  run_state_t       state_d;
  logic             en_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             skip_q;
  logic             skip_d;
  logic             div_wrap;
  logic             bp_hit;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (clk),
    .reset (reset),
    .raw   (step_btn),
    .level (step_level),
    .press (step_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
    .clk   (clk),
    .reset (reset),
    .raw   (run_btn),
    .level (run_level),
    .press (run_press)
  );

  assign div_wrap = (div_q == DIV_LAST);
  assign bp_hit   = bp_en && (pc == bp_addr) && !skip_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      halted <= 1'b0;
      cpu_en <= 1'b0;
      div_q  <= '0;
      skip_q <= 1'b0;
    end else begin
      state  <= state_d;
      halted <= (state_d == BREAK);
      cpu_en <= en_d;
      div_q  <= div_d;
      skip_q <= skip_d;
    end
  end

  // run event always takes precedence over step event
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (run_press) state_d = RUN;
      RUN: begin
        if (run_press)             state_d = IDLE;
        else if (div_wrap && bp_hit) state_d = BREAK;
      end
      BREAK: begin
        if (run_press)       state_d = RUN;
        else if (step_press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_d   = 1'b0;
    div_d  = '0;
    skip_d = skip_q;
    case (state)
      IDLE: begin
        if (!run_press && step_press) en_d = 1'b1;
      end
      RUN: begin
        if (!run_press) begin
          div_d = div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap && !bp_hit) begin
            en_d   = 1'b1;
            skip_d = 1'b0;
          end
        end
      end
      BREAK: begin
        if (run_press)       skip_d = 1'b1;
        else if (step_press) en_d   = 1'b1;
      end
      default: ;
    endcase
    // a short RUN_DIV must still never produce back-to-back enables
    if (cpu_en) en_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      instr_count <= '0;
    else if (cpu_en && (instr_count != '1))
      instr_count <= instr_count + 1'b1;
  end

  assert property (@(posedge clk) disable iff (reset) step_press |-> step_level);
  assert property (@(posedge clk) disable iff (reset) run_press |-> run_level);

endmodule

// File: tb/tb_mips_step_ctrl.sv
// tb/tb_mips_step_ctrl.sv - self-checking bench for mips_step_ctrl
module tb_mips_step_ctrl;

  localparam int DB_CYCLES = 4;
  localparam int RUN_DIV   = 3;
  localparam int PC_W      = 8;
  localparam int CNT_W     = 3;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int S_IDLE = 0, S_RUN = 1, S_BREAK = 2;

  logic             clk;
  logic             reset;
  logic             step_btn;
  logic             run_btn;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             cpu_en;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse = 0;
  int t_enter_run = 0;
  int first_lat = -1;
  int exp_pulses = 0;
  int p0;
  int p1;
  int n_rand;
  bit prev_en = 1'b0;
  bit await_first = 1'b0;
  bit gap_on = 1'b0;
  bit pc_track = 1'b0;
  logic [1:0] prev_state = 2'd0;

  mips_step_ctrl #(
    .DB_CYCLES (DB_CYCLES),
    .RUN_DIV   (RUN_DIV),
    .PC_W      (PC_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .step_btn    (step_btn),
    .run_btn     (run_btn),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .cpu_en      (cpu_en),
    .state       (state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int sat(input int p);
    return (p > CNT_MAX) ? CNT_MAX : p;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock; samples outputs at the falling edge and models the core's PC
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (int'(state) == S_RUN && int'(prev_state) != S_RUN) begin
      t_enter_run = cyc;
      await_first = 1'b1;
    end
    if (cpu_en) begin
      chk("no_back_to_back", int'(prev_en), 0);
      if (gap_on) chk("run_gap", cyc - last_pulse, RUN_DIV);
      if (await_first) begin
        first_lat   = cyc - t_enter_run;
        await_first = 1'b0;
      end
      last_pulse = cyc;
      pulses++;
      if (pc_track) pc = pc + 8'd1;
    end
    prev_en    = cpu_en;
    prev_state = state;
  endtask

  task automatic press_btns(input bit s, input bit r, input int hold);
    step_btn = s;
    run_btn  = r;
    repeat (hold) tick();
    step_btn = 1'b0;
    run_btn  = 1'b0;
    repeat (12) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset  = 1'b0;
    pulses = 0;
    exp_pulses = 0;
  endtask

  task automatic wait_state(input int target, input int budget, input string tag);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(state), target);
  endtask

  task automatic wait_pulses(input int total, input int budget, input string tag);
    int n = 0;
    while (pulses < total && n < budget) begin
      tick();
      n++;
    end
    chk(tag, (pulses >= total) ? 1 : 0, 1);
  endtask

  initial begin
    reset    = 1'b1;
    step_btn = 1'b0;
    run_btn  = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 8'h00;
    pc       = 8'h00;

    do_reset();
    chk("reset_cpu_en", int'(cpu_en), 0);
    chk("reset_state", int'(state), S_IDLE);
    chk("reset_halted", int'(halted), 0);
    chk("reset_count", int'(instr_count), 0);

    // single step: long press gives one pulse, short glitches give none
    press_btns(1'b1, 1'b0, 10);
    exp_pulses++;
    chk("step_pulses", pulses, exp_pulses);
    chk("step_count", int'(instr_count), sat(exp_pulses));
    press_btns(1'b1, 1'b0, 2);
    chk("glitch2_pulses", pulses, exp_pulses);
    for (int i = 0; i < 3; i++) begin
      press_btns(1'b1, 1'b0, $urandom_range(1, DB_CYCLES - 1));
      chk("rand_glitch_pulses", pulses, exp_pulses);
    end
    press_btns(1'b0, 1'b1, $urandom_range(1, DB_CYCLES - 1));
    chk("run_glitch_state", int'(state), S_IDLE);
    n_rand = $urandom_range(1, 3);
    for (int i = 0; i < n_rand; i++) begin
      press_btns(1'b1, 1'b0, $urandom_range(DB_CYCLES, 12));
      exp_pulses++;
    end
    chk("rand_step_pulses", pulses, exp_pulses);
    chk("rand_step_count", int'(instr_count), sat(exp_pulses));

    // free run: periodic pulses, then stop
    first_lat = -1;
    p0 = pulses;
    press_btns(1'b0, 1'b1, 10);
    chk("run_state", int'(state), S_RUN);
    chk("run_first_latency", first_lat, RUN_DIV);
    gap_on = 1'b1;
    wait_pulses(p0 + $urandom_range(4, 7), 40, "run_pulses_seen");
    press_btns(1'b0, 1'b1, 10);
    gap_on = 1'b0;
    chk("stop_state", int'(state), S_IDLE);
    p1 = pulses;
    repeat (15) tick();
    chk("stop_no_pulses", pulses, p1);
    chk("run_count", int'(instr_count), sat(pulses));

    // breakpoint at 0x10 with PC advancing one per pulse
    do_reset();
    bp_en    = 1'b1;
    bp_addr  = 8'h10;
    pc       = 8'h0E;
    pc_track = 1'b1;
    press_btns(1'b0, 1'b1, 10);
    wait_state(S_BREAK, 60, "bp_reach_break");
    chk("bp_pulses", pulses, 2);
    chk("bp_pc", int'(pc), 8'h10);
    chk("bp_halted", int'(halted), 1);
    repeat (10) tick();
    chk("bp_hold_pulses", pulses, 2);
    chk("bp_count", int'(instr_count), 2);

    // step out of BREAK
    p0 = pulses;
    press_btns(1'b1, 1'b0, 10);
    chk("brk_step_pulses", pulses - p0, 1);
    chk("brk_step_state", int'(state), S_IDLE);
    chk("brk_step_halted", int'(halted), 0);
    chk("brk_step_pc", int'(pc), 8'h11);

    // break again, then resume: runs a full PC lap back to 0x10
    pc = 8'h0E;
    p0 = pulses;
    press_btns(1'b0, 1'b1, 10);
    wait_state(S_BREAK, 60, "bp2_reach_break");
    chk("bp2_pulses", pulses - p0, 2);
    first_lat = -1;
    p0 = pulses;
    press_btns(1'b0, 1'b1, 10);
    chk("resume_first_latency", first_lat, RUN_DIV);
    wait_state(S_BREAK, 1000, "resume_rehalt");
    chk("resume_lap_pulses", pulses - p0, 1 << PC_W);
    chk("resume_pc", int'(pc), 8'h10);
    chk("resume_halted", int'(halted), 1);
    pc_track = 1'b0;
    bp_en    = 1'b0;

    // reset one cycle before a due pulse
    do_reset();
    press_btns(1'b0, 1'b1, 10);
    p0 = pulses;
    wait_pulses(p0 + 1, 10, "rst_pulse_seen");
    tick();
    tick();
    reset  = 1'b1;
    pulses = 0;
    tick();
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_state", int'(state), S_IDLE);
    chk("rst_count", int'(instr_count), 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("rst_no_pulses", pulses, 0);

    // simultaneous step and run: run wins; counter saturates
    first_lat = -1;
    press_btns(1'b1, 1'b1, 10);
    chk("both_state", int'(state), S_RUN);
    chk("both_first_latency", first_lat, RUN_DIV);
    wait_pulses(9, 60, "sat_pulses_seen");
    tick();
    chk("sat_count", int'(instr_count), sat(pulses));
    chk("sat_value", int'(instr_count), CNT_MAX);
    press_btns(1'b0, 1'b1, 10);
    chk("sat_stop_state", int'(state), S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
